// File: rtl/kbd_player_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : kbd_player_ctrl_if
// Brief    : Flash word-read handshake between the player controller and flash.
// Revision : 1.0 - initial release
// ============================================================================
interface kbd_player_ctrl_if #(
    parameter int ADDR_W = 23
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [31:0]       rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface
`default_nettype wire

// File: rtl/kbd_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : kbd_player_ctrl
// Brief    : Turns decoder key edges into player commands and walks the flash
//            sample address, one read per sample tick.
// Revision : 1.0 - initial release
// ============================================================================
module kbd_player_ctrl #(
    parameter int                ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               D,
    input  wire logic               E,
    input  wire logic               B,
    input  wire logic               F,
    input  wire logic               R,
    input  wire logic               sample_tick,
    kbd_player_ctrl_if.master       flash,
    output logic [31:0]             sample_data,
    output logic                    sample_valid,
    output logic                    playing,
    output logic                    reverse,
    output logic                    restart_pulse,
    output logic                    overrun
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_step = 2'd2;

    localparam logic [ADDR_W-1:0] c_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [4:0]        key_q, key_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              playing_q, playing_d;
    logic              reverse_q, reverse_d;
    logic              restart_pending_q, restart_pending_d;
    logic              restart_pulse_q, restart_pulse_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       sample_data_q, sample_data_d;

    logic [4:0]        key_vec;
    logic [4:0]        key_rise;
    logic [ADDR_W-1:0] restart_val;
    logic [ADDR_W-1:0] step_val;

    // Bit order {D,E,B,F,R}
    assign key_vec  = {D, E, B, F, R};
    assign key_rise = key_vec & ~key_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (sample_tick && playing_q) state_d = c_st_req;
            c_st_req:  if (flash.rd_ack)             state_d = c_st_step;
            c_st_step: state_d = c_st_idle;
            default:   state_d = c_st_idle;
        endcase
    end

    // Output logic
    always_comb begin
        flash.rd_req = (state_q == c_st_req);
        sample_valid = (state_q == c_st_step);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q             <= 5'b0;
            addr_q            <= START_ADDR;
            playing_q         <= 1'b0;
            reverse_q         <= 1'b0;
            restart_pending_q <= 1'b0;
            restart_pulse_q   <= 1'b0;
            overrun_q         <= 1'b0;
            sample_data_q     <= 32'h0;
        end else begin
            key_q             <= key_d;
            addr_q            <= addr_d;
            playing_q         <= playing_d;
            reverse_q         <= reverse_d;
            restart_pending_q <= restart_pending_d;
            restart_pulse_q   <= restart_pulse_d;
            overrun_q         <= overrun_d;
            sample_data_q     <= sample_data_d;
        end
    end

    // Stop beats start and backward beats forward on simultaneous edges
    always_comb begin
        key_d     = key_vec;
        playing_d = playing_q;
        reverse_d = reverse_q;
        if (key_rise[4])      playing_d = 1'b0;
        else if (key_rise[3]) playing_d = 1'b1;
        if (key_rise[2])      reverse_d = 1'b1;
        else if (key_rise[1]) reverse_d = 1'b0;
    end

    always_comb begin
        restart_val = reverse_d ? END_ADDR : START_ADDR;
        if (reverse_q) begin
            step_val = (addr_q == START_ADDR) ? END_ADDR : (addr_q - c_one);
        end else begin
            step_val = (addr_q == END_ADDR) ? START_ADDR : (addr_q + c_one);
        end
    end

    // Address only moves in IDLE or STEP, so rd_addr is frozen throughout REQ
    always_comb begin
        addr_d            = addr_q;
        restart_pending_d = restart_pending_q;
        restart_pulse_d   = 1'b0;
        overrun_d         = 1'b0;
        sample_data_d     = sample_data_q;
        case (state_q)
            c_st_idle: begin
                if (key_rise[0]) begin
                    addr_d          = restart_val;
                    restart_pulse_d = 1'b1;
                end
            end
            c_st_req: begin
                if (key_rise[0])  restart_pending_d = 1'b1;
                if (flash.rd_ack) sample_data_d     = flash.rd_data;
                if (sample_tick)  overrun_d         = 1'b1;
            end
            c_st_step: begin
                if (restart_pending_q || key_rise[0]) begin
                    addr_d            = restart_val;
                    restart_pending_d = 1'b0;
                    restart_pulse_d   = 1'b1;
                end else begin
                    addr_d = step_val;
                end
                if (sample_tick) overrun_d = 1'b1;
            end
            default: begin
                addr_d = addr_q;
            end
        endcase
    end

    assign flash.rd_addr = addr_q;
    assign sample_data   = sample_data_q;
    assign playing       = playing_q;
    assign reverse       = reverse_q;
    assign restart_pulse = restart_pulse_q;
    assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_player_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_kbd_player_ctrl
// Brief    : Self-checking bench for kbd_player_ctrl with a read scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_player_ctrl;

    localparam int          ADDR_W  = 23;
    localparam logic [22:0] C_START = 23'h000000;
    localparam logic [22:0] C_END   = 23'h07FFFF;
    localparam logic [4:0]  K_D = 5'b10000;
    localparam logic [4:0]  K_E = 5'b01000;
    localparam logic [4:0]  K_B = 5'b00100;
    localparam logic [4:0]  K_F = 5'b00010;
    localparam logic [4:0]  K_R = 5'b00001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        D = 1'b0, E = 1'b0, B = 1'b0, F = 1'b0, R = 1'b0;
    logic        sample_tick = 1'b0;
    logic [31:0] sample_data;
    logic        sample_valid, playing, reverse, restart_pulse, overrun;

    kbd_player_ctrl_if #(.ADDR_W(ADDR_W)) flash ();

    kbd_player_ctrl #(
        .ADDR_W     (ADDR_W),
        .START_ADDR (C_START),
        .END_ADDR   (C_END)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .D             (D),
        .E             (E),
        .B             (B),
        .F             (F),
        .R             (R),
        .sample_tick   (sample_tick),
        .flash         (flash.master),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .playing       (playing),
        .reverse       (reverse),
        .restart_pulse (restart_pulse),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [22:0] obs_addr_q[$];
    logic [31:0] obs_data_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int valid_cnt = 0, ov_cnt = 0, rp_cnt = 0, start_cnt = 0;
    logic playing_prev = 1'b0;

    logic [22:0] exp_addr = C_START;
    logic        exp_rev  = 1'b0;

    always @(negedge clk) begin
        if (flash.rd_req && flash.rd_ack) obs_addr_q.push_back(flash.rd_addr);
        if (sample_valid) begin
            obs_data_q.push_back(sample_data);
            valid_cnt++;
        end
        if (overrun) ov_cnt++;
        if (restart_pulse) rp_cnt++;
        if (playing && !playing_prev) start_cnt++;
        playing_prev = playing;
    end

    function automatic logic [22:0] step_addr(input logic [22:0] a, input logic rev);
        if (rev) return (a == C_START) ? C_END : a - 23'd1;
        return (a == C_END) ? C_START : a + 23'd1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] m);
        {D, E, B, F, R} = m;
        cyc();
        {D, E, B, F, R} = 5'b0;
    endtask

    // One sample read: tick, hold REQ for wait_n cycles, then ack; checks and scoreboard drain
    task automatic do_read(input logic [31:0] data, input int wait_n, input int r_at,
                           input logic [15:0] tick_mask, input bit restart);
        exp_t e;
        exp_t p;
        int   v0;
        logic [22:0] oa;
        logic [31:0] od;
        e.addr = exp_addr;
        e.data = data;
        exp_q.push_back(e);
        v0 = valid_cnt;
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        for (int i = 0; i <= wait_n; i++) begin
            n_cmp++;
            if (flash.rd_req !== 1'b1 || flash.rd_addr !== exp_addr) begin
                n_err++;
                $display("FAIL read_hold cycle %0d: rd_req=%b rd_addr=%h, required rd_req=1 rd_addr=%h",
                         i, flash.rd_req, flash.rd_addr, exp_addr);
            end
            if (i < wait_n) begin
                R = (i == r_at);
                sample_tick = tick_mask[i];
                cyc();
                R = 1'b0;
                sample_tick = 1'b0;
            end
        end
        flash.rd_ack  = 1'b1;
        flash.rd_data = data;
        cyc();
        flash.rd_ack  = 1'b0;
        flash.rd_data = $urandom;
        n_cmp++;
        if (flash.rd_req !== 1'b0 || sample_valid !== 1'b1) begin
            n_err++;
            $display("FAIL step_cycle: rd_req=%b sample_valid=%b, required 0 and 1",
                     flash.rd_req, sample_valid);
        end
        cyc();
        n_cmp++;
        if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL valid_width: sample_valid=%b, required 0", sample_valid);
        end
        exp_addr = restart ? (exp_rev ? C_END : C_START) : step_addr(exp_addr, exp_rev);
        n_cmp++;
        if (flash.rd_addr !== exp_addr) begin
            n_err++;
            $display("FAIL next_addr: addr=%h, required %h", flash.rd_addr, exp_addr);
        end
        n_cmp++;
        if (valid_cnt - v0 != 1) begin
            n_err++;
            $display("FAIL valid_count: pulses=%0d, required 1", valid_cnt - v0);
        end
        n_cmp++;
        if (exp_q.size() == 0 || obs_addr_q.size() == 0 || obs_data_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: exp=%0d addr_obs=%0d data_obs=%0d, required all nonzero",
                     exp_q.size(), obs_addr_q.size(), obs_data_q.size());
        end else begin
            p  = exp_q.pop_front();
            oa = obs_addr_q.pop_front();
            od = obs_data_q.pop_front();
            if (oa !== p.addr || od !== p.data) begin
                n_err++;
                $display("FAIL scoreboard: addr=%h data=%h, required addr=%h data=%h",
                         oa, od, p.addr, p.data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        n_cmp++;
        if (flash.rd_req !== 1'b0 || flash.rd_addr !== C_START || playing !== 1'b0 ||
            reverse !== 1'b0 || sample_data !== 32'h0 || sample_valid !== 1'b0 ||
            overrun !== 1'b0 || restart_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: req=%b addr=%h play=%b rev=%b data=%h valid=%b ovr=%b rp=%b, required all zero",
                     flash.rd_req, flash.rd_addr, playing, reverse, sample_data,
                     sample_valid, overrun, restart_pulse);
        end
    endtask

    task automatic test_first_read();
        press(K_E);
        n_cmp++;
        if (playing !== 1'b1) begin
            n_err++;
            $display("FAIL start_cmd: playing=%b, required 1", playing);
        end
        do_read(32'hA5A5_0001, 1, -1, 16'h0, 1'b0);
        n_cmp++;
        if (sample_data !== 32'hA5A5_0001 || flash.rd_addr !== 23'd1) begin
            n_err++;
            $display("FAIL first_read: data=%h addr=%h, required A5A50001 and 1",
                     sample_data, flash.rd_addr);
        end
    endtask

    task automatic test_wrap();
        press(K_B | K_R);
        exp_rev  = 1'b1;
        exp_addr = C_END;
        n_cmp++;
        if (flash.rd_addr !== C_END || reverse !== 1'b1 || restart_pulse !== 1'b1) begin
            n_err++;
            $display("FAIL idle_restart: addr=%h rev=%b rp=%b, required %h 1 1",
                     flash.rd_addr, reverse, restart_pulse, C_END);
        end
        press(K_F);
        exp_rev = 1'b0;
        n_cmp++;
        if (reverse !== 1'b0 || restart_pulse !== 1'b0 || flash.rd_addr !== C_END) begin
            n_err++;
            $display("FAIL forward_cmd: rev=%b rp=%b addr=%h, required 0 0 %h",
                     reverse, restart_pulse, flash.rd_addr, C_END);
        end
        do_read(32'h1111_2222, 1, -1, 16'h0, 1'b0);
        press(K_B);
        exp_rev = 1'b1;
        do_read(32'h3333_4444, 0, -1, 16'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int ov0;
        press(K_F | K_R);
        exp_rev  = 1'b0;
        exp_addr = C_START;
        ov0 = ov_cnt;
        for (int i = 0; i < 100; i++) do_read($urandom, 0, -1, 16'h0, 1'b0);
        n_cmp++;
        if (ov_cnt != ov0 || flash.rd_addr !== 23'd100) begin
            n_err++;
            $display("FAIL back_to_back: overruns=%0d addr=%h, required 0 and 64",
                     ov_cnt - ov0, flash.rd_addr);
        end
    endtask

    task automatic test_restart_req();
        int rp0;
        press(K_B);
        exp_rev = 1'b1;
        rp0 = rp_cnt;
        do_read(32'hDEAD_0100, 3, 0, 16'h0, 1'b1);
        n_cmp++;
        if (restart_pulse !== 1'b1 || flash.rd_addr !== C_END) begin
            n_err++;
            $display("FAIL req_restart: rp=%b addr=%h, required 1 %h",
                     restart_pulse, flash.rd_addr, C_END);
        end
        cyc();
        n_cmp++;
        if (restart_pulse !== 1'b0 || rp_cnt - rp0 != 1) begin
            n_err++;
            $display("FAIL restart_once: rp=%b pulses=%0d, required 0 and 1",
                     restart_pulse, rp_cnt - rp0);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        ov0 = ov_cnt;
        do_read(32'hC0DE_0007, 10, -1, 16'h0044, 1'b0);
        n_cmp++;
        if (ov_cnt - ov0 != 2 || flash.rd_addr !== C_END - 23'd1) begin
            n_err++;
            $display("FAIL overrun: pulses=%0d addr=%h, required 2 and %h",
                     ov_cnt - ov0, flash.rd_addr, C_END - 23'd1);
        end
    endtask

    task automatic test_stop_wins();
        int ov0;
        press(K_D | K_E);
        n_cmp++;
        if (playing !== 1'b0) begin
            n_err++;
            $display("FAIL stop_wins: playing=%b, required 0", playing);
        end
        ov0 = ov_cnt;
        for (int i = 0; i < 3; i++) begin
            sample_tick = 1'b1;
            cyc();
            sample_tick = 1'b0;
            n_cmp++;
            if (flash.rd_req !== 1'b0) begin
                n_err++;
                $display("FAIL stopped_tick %0d: rd_req=%b, required 0", i, flash.rd_req);
            end
            cyc();
        end
        n_cmp++;
        if (ov_cnt != ov0) begin
            n_err++;
            $display("FAIL stopped_overrun: pulses=%0d, required 0", ov_cnt - ov0);
        end
    endtask

    task automatic test_held_key();
        int s0;
        s0 = start_cnt;
        E = 1'b1;
        repeat (50) cyc();
        n_cmp++;
        if (playing !== 1'b1 || start_cnt - s0 != 1) begin
            n_err++;
            $display("FAIL held_start: playing=%b starts=%0d, required 1 and 1",
                     playing, start_cnt - s0);
        end
        D = 1'b1;
        cyc();
        D = 1'b0;
        repeat (5) cyc();
        n_cmp++;
        if (playing !== 1'b0 || start_cnt - s0 != 1) begin
            n_err++;
            $display("FAIL held_stop: playing=%b starts=%0d, required 0 and 1",
                     playing, start_cnt - s0);
        end
        E = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_req();
        int v0;
        press(K_E);
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
        n_cmp++;
        if (flash.rd_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_req: rd_req=%b, required 1", flash.rd_req);
        end
        v0 = valid_cnt;
        reset = 1'b1;
        cyc();
        n_cmp++;
        if (flash.rd_req !== 1'b0 || flash.rd_addr !== C_START || playing !== 1'b0 || reverse !== 1'b0) begin
            n_err++;
            $display("FAIL mid_req_reset: rd_req=%b addr=%h play=%b rev=%b, required 0 0 0 0",
                     flash.rd_req, flash.rd_addr, playing, reverse);
        end
        reset = 1'b0;
        flash.rd_ack = 1'b1;
        cyc();
        flash.rd_ack = 1'b0;
        cyc();
        cyc();
        n_cmp++;
        if (valid_cnt != v0 || flash.rd_req !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL late_ack: valid=%0d rd_req=%b pending_exp=%0d, required 0 0 0",
                     valid_cnt - v0, flash.rd_req, exp_q.size());
        end
    endtask

    initial begin
        flash.rd_ack  = 1'b0;
        flash.rd_data = 32'h0;
        test_reset();
        test_first_read();
        test_wrap();
        test_back_to_back();
        test_restart_req();
        test_overrun();
        test_stop_wins();
        test_held_key();
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_player_ctrl.md
# kbd_player_ctrl

Command and address sequencer directly downstream of the keyboard character decoder. It takes the decoder's level outputs (D, E, B, F, R) and turns each rising edge into a single player command: stop, start, backward, forward or restart. It also walks a sample address through flash, issuing one read request per sample tick and passing each returned word on to the audio path.

## Interface
Parameters:
- ADDR_W, 23, width of the flash word address.
- START_ADDR, 23'h000000, first sample address.
- END_ADDR, 23'h07FFFF, last sample address (must be greater than START_ADDR).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- D  in  1  decoder level: stop.
- E  in  1  decoder level: start.
- B  in  1  decoder level: play backward.
- F  in  1  decoder level: play forward.
- R  in  1  decoder level: restart.
- sample_tick  in  1  one-cycle strobe at the audio sample rate.
- rd_ack  in  1  flash read complete; rd_data is valid in the same cycle.
- rd_data  in  32  flash read data.
- rd_req  out  1  flash read request; held until rd_ack.
- rd_addr  out  ADDR_W  address of the current read (equals addr).
- sample_data  out  32  last word returned by flash.
- sample_valid  out  1  one-cycle pulse when sample_data updates.
- playing  out  1  1 = playback enabled.
- reverse  out  1  1 = addresses decrement.
- restart_pulse  out  1  one-cycle pulse when a restart is applied to addr.
- overrun  out  1  one-cycle pulse when sample_tick is dropped.

## Operation
- Edge detection:
  - key_q[4:0] registers {D,E,B,F,R} every cycle; rise = key & ~key_q.
  - key_q resets to 0, so a key held through reset produces one event after reset.
  - Levels held high produce no further events.
- Command effects, registered on the edge where the rise is seen:
  - E: playing<=1.
  - D: playing<=0.
  - B: reverse<=1.
  - F: reverse<=0.
  - R: restart; does not change playing.
- Simultaneous rises:
  - D and E together: D wins (playing<=0).
  - B and F together: B wins.
  - R combines with any of the above; all non-conflicting effects apply in the same cycle.
- Restart:
  - In IDLE: addr <= (reverse_next ? END_ADDR : START_ADDR), with restart_pulse in the following cycle. reverse_next is the value of reverse after this cycle's B/F update.
  - In REQ or STEP: sets restart_pending. The STEP cycle loads the restart value instead of stepping, then clears restart_pending and pulses restart_pulse.
- State machine (IDLE, REQ, STEP):
  - IDLE: sample_tick & playing -> REQ. sample_tick & ~playing is ignored, with no overrun.
  - REQ: rd_req=1, rd_addr=addr. On rd_ack, sample_data<=rd_data and go to STEP. Stays in REQ indefinitely without rd_ack. A D command in REQ does not abort the read.
  - STEP: sample_valid=1. addr updates using reverse as it stands in this cycle:
    - forward: END_ADDR wraps to START_ADDR, otherwise +1.
    - reverse: START_ADDR wraps to END_ADDR, otherwise -1.
  - STEP always returns to IDLE.
- sample_tick while in REQ or STEP: dropped, overrun=1 for one cycle; the state machine is unaffected.
- Arithmetic is ADDR_W-bit; wrap is explicit by compare, never by natural overflow.
- Reset values: state=IDLE, addr=START_ADDR, playing=0, reverse=0, rd_req=0, sample_data=0, sample_valid=0, restart_pulse=0, overrun=0, restart_pending=0, key_q=0. Reset mid-read drops rd_req the next cycle; a late rd_ack is ignored.

## Timing
- Command latency: a key high and key_q low at edge k -> playing/reverse change after edge k.
- rd_req latency: sample_tick at edge k in IDLE (playing=1) -> rd_req high from after edge k.
- rd_ack sampled at edge m -> rd_req low and sample_valid high after edge m, for one cycle. addr shows the new value after edge m+1.
- Minimum sample period: 3 cycles (tick, ack in the next cycle, STEP). A tick during STEP is an overrun.
- rd_addr is stable for the whole time rd_req is high. R/B/F during REQ never alter rd_addr.

## Test plan
- Reset, then E rise, then tick with rd_ack 2 cycles later (rd_data=32'hA5A5_0001) -> rd_addr=0, sample_data=32'hA5A5_0001, one sample_valid pulse, addr=1.
- Forward wrap: addr=23'h07FFFF, one tick+ack -> addr=0. Then B rise, one tick+ack -> addr=23'h07FFFF.
- D and E rise in the same cycle while playing=1 -> playing=0. Subsequent ticks produce no rd_req and no overrun.
- R during REQ with reverse=1 and addr=100 -> rd_addr stays 100 until ack. After STEP, addr=23'h07FFFF and restart_pulse fires once.
- rd_ack withheld 10 cycles while ticks arrive at cycles 3 and 7 -> two overrun pulses, one read, rd_req continuously high.
- E held high for 50 cycles, then D rise, then E still held -> exactly one start event and playing=0 at the end. Reset asserted mid-REQ -> rd_req=0 and addr=0 the next cycle.
